// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, buffer state
// encoding and the buffered result-entry layout.
package alu_pkg;

    // ALU opcodes as produced by the upstream Alu
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // Widest destination tag an entry can carry; narrower tags are zero-extended
    localparam int DEST_MAX_W = 16;

    // Occupancy of the result buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // One buffered ALU result
    typedef struct packed {
        logic [31:0]           result;
        logic [DEST_MAX_W-1:0] dest;
        logic                  wr_en;
        logic                  comp;
    } result_entry_t;

    // Only add and subtract can raise a meaningful overflow
    function automatic logic is_trap_op(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the Alu, the result stage and the
// memory stage. The stage connects through the slave modport.
interface alu_result_stage_if #(
    parameter int DEST_W = 5,
    parameter int CNT_W  = 8
);
    // Upstream (ALU) side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [31:0]       aluout;
    logic              overflow;
    logic              compout;
    logic [DEST_W-1:0] dest;

    // Downstream (memory stage) side
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              out_wr_en;
    logic              out_comp;

    // Trap reporting
    logic              trap;
    logic              trap_clr;
    logic [CNT_W-1:0]  ovf_count;

    modport master (
        output in_valid, op, aluout, overflow, compout, dest, out_ready, trap_clr,
        input  in_ready, out_valid, out_result, out_dest, out_wr_en, out_comp, trap, ovf_count
    );

    modport slave (
        input  in_valid, op, aluout, overflow, compout, dest, out_ready, trap_clr,
        output in_ready, out_valid, out_result, out_dest, out_wr_en, out_comp, trap, ovf_count
    );

endinterface

// File: rtl/alu_result_entry.sv
// Loadable register holding one result entry; used for the main slot and,
// in the skid build, for the skid slot.
module alu_result_entry
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  result_entry_t d,
    output result_entry_t q
);

    // Capture a new entry when load is asserted, otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the entry is reset because its zero value is visible on the stage outputs after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage result register behind the Alu. Buffers results under a
// valid/ready handshake, suppresses write-back of overflowing add/sub
// results and keeps a sticky trap flag plus a saturating overflow count.
// Build option: define ALU_SKID_EN for a two-entry skid buffer with a
// registered in_ready; otherwise a single entry whose in_ready follows
// out_ready combinationally.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEST_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_stage_if.slave bus
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    result_entry_t    in_entry;
    result_entry_t    main_d;
    result_entry_t    main_q;
    logic             main_load;
    logic             push;
    logic             pop;
    logic             trap_hit;
    logic             trap_q;
    logic [CNT_W-1:0] ovf_count_q;
    logic             unused_dest_hi;

    assign push     = bus.in_valid && bus.in_ready;
    assign pop      = bus.out_valid && bus.out_ready;
    assign trap_hit = push && bus.overflow && is_trap_op(bus.op);

    // Form the entry to store: write-back is blocked for trapped or zero-tag results.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_entry        = '0;
        in_entry.result = bus.aluout;
        in_entry.dest   = DEST_MAX_W'(bus.dest);
        in_entry.wr_en  = !(bus.overflow && is_trap_op(bus.op)) && (bus.dest != '0);
        in_entry.comp   = bus.compout;
    end

`ifdef ALU_SKID_EN
    result_entry_t skid_q;
    logic          skid_load;
    logic          in_ready_q;

    // Next buffer state and slot load controls for the two-entry buffer.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = in_entry;
        skid_load = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (push) begin
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    alu_result_entry u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    // in_ready is a flop: low exactly while both slots are occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign bus.in_ready = in_ready_q;
`else
    // Next buffer state for the single-entry buffer; main reloads on every accept.
    always_comb begin
        state_d   = state_q;
        main_load = push;
        main_d    = in_entry;
        case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE:   if (pop && !push) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Accept whenever the slot is free or is being drained this cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
`endif

    alu_result_entry u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky trap: a new trap on the same edge as trap_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (trap_hit) begin
            trap_q <= 1'b1;
        end else if (bus.trap_clr) begin
            trap_q <= 1'b0;
        end
    end

    // Count trapped entries, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else if (trap_hit && (ovf_count_q != '1)) begin
            ovf_count_q <= ovf_count_q + CNT_W'(1);
        end
    end

    // Tag bits above DEST_W are always zero-extended and carry no information.
    assign unused_dest_hi = |(main_q.dest >> DEST_W);

    assign bus.out_valid  = (state_q != ST_EMPTY);
    assign bus.out_result = main_q.result;
    assign bus.out_dest   = main_q.dest[DEST_W-1:0];
    assign bus.out_wr_en  = main_q.wr_en;
    assign bus.out_comp   = main_q.comp;
    assign bus.trap       = trap_q;
    assign bus.ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage. Expected entries are queued when
// the bench drives an accepted input and compared when the stage transfers
// an entry out; trap and counter follow a small reference model.
module tb_alu_result_stage;

    localparam int DEST_W = 5;
    localparam int CNT_W  = 8;
`ifdef ALU_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0]       result;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
        logic              comp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    alu_result_stage_if #(.DEST_W(DEST_W), .CNT_W(CNT_W)) bus ();

    alu_result_stage #(.DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    logic       exp_trap = 1'b0;
    logic [7:0] exp_cnt  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        check({tag, "_out_result"}, bus.out_result,      32'd0);
        check({tag, "_out_dest"},   32'(bus.out_dest),   32'd0);
        check({tag, "_out_wr_en"},  32'(bus.out_wr_en),  32'd0);
        check({tag, "_out_comp"},   32'(bus.out_comp),   32'd0);
        check({tag, "_trap"},       32'(bus.trap),       32'd0);
        check({tag, "_ovf_count"},  32'(bus.ovf_count),  32'd0);
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] res,
                        input logic ovf, input logic cmp, input logic [DEST_W-1:0] dst,
                        input logic clr, output logic accepted);
        exp_t e;
        exp_t got;
        logic exp_ready;
        logic tr;
        bus.in_valid = v;
        bus.op       = op;
        bus.aluout   = res;
        bus.overflow = ovf;
        bus.compout  = cmp;
        bus.dest     = dst;
        bus.trap_clr = clr;
        #1;
        exp_ready = (DEPTH == 2) ? (sb.size() < 2) : ((sb.size() == 0) || bus.out_ready);
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
        accepted = v && exp_ready;
        if ((sb.size() != 0) && bus.out_ready) begin
            got = sb.pop_front();
            check("out_result", bus.out_result,     got.result);
            check("out_dest",   32'(bus.out_dest),  32'(got.dest));
            check("out_wr_en",  32'(bus.out_wr_en), 32'(got.wr_en));
            check("out_comp",   32'(bus.out_comp),  32'(got.comp));
        end
        tr = accepted && ovf && ((op == 3'b010) || (op == 3'b110));
        if (accepted) begin
            e        = '0;
            e.result = res;
            e.dest   = dst;
            e.wr_en  = !(ovf && ((op == 3'b010) || (op == 3'b110))) && (dst != '0);
            e.comp   = cmp;
            sb.push_back(e);
        end
        if (tr) begin
            exp_trap = 1'b1;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end else if (clr) begin
            exp_trap = 1'b0;
        end
        @(posedge clk);
        #1;
        check("trap",      32'(bus.trap),      32'(exp_trap));
        check("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
        @(negedge clk);
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, 3'b000, 32'd0, 1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    initial begin
        logic       acc;
        int         idx;
        int         guard;
        logic [2:0] ops[6];
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.aluout    = 32'd0;
        bus.overflow  = 1'b0;
        bus.compout   = 1'b0;
        bus.dest      = '0;
        bus.trap_clr  = 1'b0;
        bus.out_ready = 1'b1;

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain add
        step(1'b1, 3'b010, 32'h0000_0005, 1'b0, 1'b0, 5'd3, 1'b0, acc);
        idle();

        // Overflowing add traps, then trap_clr clears it
        step(1'b1, 3'b010, 32'h8000_0000, 1'b1, 1'b0, 5'd7, 1'b0, acc);
        check("first_trap_count", 32'(bus.ovf_count), 32'd1);
        step(1'b0, 3'b000, 32'd0, 1'b0, 1'b0, '0, 1'b1, acc);

        // Overflow on xor is ignored
        step(1'b1, 3'b101, 32'h1234_5678, 1'b1, 1'b1, 5'd4, 1'b0, acc);
        idle();

        // Zero tag never writes back
        step(1'b1, 3'b010, 32'd9, 1'b0, 1'b0, 5'd0, 1'b0, acc);
        idle();

        // Trap and trap_clr on the same edge: trap stays set
        step(1'b1, 3'b110, 32'hFFFF_0000, 1'b1, 1'b0, 5'd2, 1'b1, acc);
        step(1'b0, 3'b000, 32'd0, 1'b0, 1'b0, '0, 1'b1, acc);

        // Back-to-back 1,2,3 against a stalled consumer
        bus.out_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 3'b010, 32'(idx), 1'b0, 1'b0, 5'(idx), 1'b0, acc);
            if (acc) idx++;
        end
        check("held_off_count", 32'(idx - 1), 32'(DEPTH));
        bus.out_ready = 1'b1;
        guard = 0;
        while (((idx <= 3) || (sb.size() != 0)) && (guard < 20)) begin
            step(idx <= 3, 3'b010, 32'(idx), 1'b0, 1'b0, 5'(idx), 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        check("ordered_drain_left", 32'(sb.size()), 32'd0);

        // Random traffic with random back-pressure
        for (int c = 0; c < 60; c++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)], $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0), acc);
        end
        bus.out_ready = 1'b1;
        guard = 0;
        while ((sb.size() != 0) && (guard < 10)) begin
            idle();
            guard++;
        end
        check("random_drain_left", 32'(sb.size()), 32'd0);

        // 300 trapped subtracts saturate the counter
        for (int c = 0; c < 300; c++) begin
            step(1'b1, 3'b110, 32'(c), 1'b1, 1'b0, 5'(c), 1'b0, acc);
        end
        check("ovf_saturated", 32'(bus.ovf_count), 32'd255);

        // Reset in the middle of a transfer clears everything at once
        bus.in_valid = 1'b1;
        bus.aluout   = 32'hDEAD_BEEF;
        #3 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        sb.delete();
        exp_trap     = 1'b0;
        exp_cnt      = 8'h00;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Stage works normally after reset
        step(1'b1, 3'b001, 32'hA5A5_0001, 1'b0, 1'b1, 5'd17, 1'b0, acc);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
